// File: rtl/bias_add_stage.sv
// bias_add_stage: adds a per-lane bias to an adder-tree output word and
// serialises the saturated lane results one beat per transfer.
// Optional feature: define BIAS_ADD_RELU_EN to clamp negative results to 0.
module bias_add_stage #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    localparam int LANE_W      = $clog2(N_adder_tree)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_sum,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_W-1:0]       out_data,
    output logic [LANE_W-1:0]              out_lane,
    output logic                           out_last
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_adder_tree - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [LANE_W-1:0]         r_lane;
    logic [LANE_W-1:0]         w_lane_next;
    logic signed [DATA_W-1:0]  r_buf [N_adder_tree];
    logic                      w_accept;
    logic                      w_beat;
    logic                      w_is_last;

    // Widen both operands by one sign bit so the sum never wraps, then clamp
    // to the DATA_W range when the two top bits disagree.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            if (s[DATA_W] == 1'b0) begin
                sat_add = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                sat_add = {1'b1, {(DATA_W-1){1'b0}}};
            end
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

    // Activation applied after saturation; purely combinational, no latency.
    function automatic logic signed [DATA_W-1:0] act_fn(
        input logic signed [DATA_W-1:0] x
    );
`ifdef BIAS_ADD_RELU_EN
        act_fn = x[DATA_W-1] ? '0 : x;
`else
        act_fn = x;
`endif
    endfunction

    assign w_is_last = (r_lane == LAST_LANE);
    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_beat    = (r_state == S_STREAM) && out_ready;

    // Next-state and lane-counter logic; the lane counter only advances on
    // a completed transfer so stalled beats hold their lane.
    always_comb begin
        w_state_next = r_state;
        w_lane_next  = r_lane;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_STREAM;
                    w_lane_next  = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (w_is_last) begin
                        w_state_next = S_IDLE;
                        w_lane_next  = '0;
                    end else begin
                        w_lane_next  = r_lane + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_lane_next  = '0;
            end
        endcase
    end

    // State and lane registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_next;
            r_lane  <= w_lane_next;
        end
    end

    // Lane buffer: bias is sampled only on the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_adder_tree; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < N_adder_tree; k++) begin
                r_buf[k] <= act_fn(sat_add(in_sum[k*DATA_W +: DATA_W],
                                           bias[k*DATA_W +: DATA_W]));
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_STREAM);
    assign out_lane  = r_lane;
    assign out_last  = out_valid && w_is_last;
    assign out_data  = out_valid ? r_buf[r_lane] : '0;

    // w_beat is kept for readability of the handshake; tie it off here.
    logic w_unused;
    assign w_unused = w_beat;

endmodule
